// File: rtl/lock_pkg.sv
// Shared state encoding, keypad constants and small helpers for the keypad lock.
package lock_pkg;

  typedef enum logic [2:0] {
    S_ENTRY   = 3'd0,
    S_CHECK   = 3'd1,
    S_OPEN    = 3'd2,
    S_PROG    = 3'd3,
    S_FAIL    = 3'd4,
    S_LOCKOUT = 3'd5
  } state_t;

  localparam logic [3:0] KEY_CLR = 4'd10;
  localparam logic [3:0] KEY_ENT = 4'd11;

  // Codes 0-9 are digits; 10/11 are commands; 12-15 are unused.
  function automatic logic is_digit(input logic [3:0] code);
    return (code <= 4'd9);
  endfunction

  // Failure counter saturates so a long run of bad entries cannot wrap to zero.
  function automatic logic [1:0] sat_inc(input logic [1:0] v);
    return (v == 2'b11) ? v : v + 2'd1;
  endfunction

endpackage

// File: rtl/lock_timer.sv
// Loadable down-counter used for both the unlock window and the lockout period.
module lock_timer (
  input  logic        clock,
  input  logic        reset,
  input  logic        load,
  input  logic [31:0] value,
  output logic        zero
);

  logic [31:0] count;

  // Load takes priority; otherwise count down and hold at zero.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= value;
    end else if (count != 32'd0) begin
      count <= count - 32'd1;
    end
  end

  assign zero = (count == 32'd0);

endmodule

// File: rtl/lock_ctrl.sv
// Keypad lock controller: code entry, unlock window, password change and lockout.
module lock_ctrl
  import lock_pkg::*;
#(
  parameter logic [15:0] DEFAULT_PW     = 16'h1234,
  parameter logic [31:0] UNLOCK_CYCLES  = 32'd1000,
  parameter logic [31:0] LOCKOUT_CYCLES = 32'd5000,
  parameter logic [1:0]  MAX_FAIL       = 2'd3
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] Code,
  input  logic       Valid,
  output logic       unlock,
  output logic       alarm,
  output logic       err,
  output logic       prog,
  output logic [2:0] digit_cnt
);

  state_t      st;
  logic [15:0] entry_buf;
  logic [15:0] pw;
  logic [1:0]  fail_cnt;
  logic        key_dig;
  logic        key_clr;
  logic        key_ent;
  logic        match;
  logic        tmr_load;
  logic [31:0] tmr_val;
  logic        tmr_zero;

  // Decode the strobed key once so the FSM only sees qualified events.
  always_comb begin
    key_dig = Valid && is_digit(Code);
    key_clr = Valid && (Code == KEY_CLR);
    key_ent = Valid && (Code == KEY_ENT);
    match   = (entry_buf == pw);
  end

  // Reload the timer on the same edge the FSM enters OPEN or LOCKOUT.
  always_comb begin
    tmr_load = 1'b0;
    tmr_val  = '0;
    if ((st == S_CHECK && match) || (st == S_PROG && key_clr)) begin
      tmr_load = 1'b1;
      tmr_val  = UNLOCK_CYCLES - 32'd1;
    end else if (st == S_FAIL && fail_cnt >= MAX_FAIL) begin
      tmr_load = 1'b1;
      tmr_val  = LOCKOUT_CYCLES - 32'd1;
    end
  end

  lock_timer u_timer (
    .clock (clock),
    .reset (reset),
    .load  (tmr_load),
    .value (tmr_val),
    .zero  (tmr_zero)
  );

  // Main FSM; every output is updated alongside the state it belongs to.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      st        <= S_ENTRY;
      entry_buf <= '0;
      digit_cnt <= '0;
      fail_cnt  <= '0;
      pw        <= DEFAULT_PW;
      unlock    <= 1'b0;
      alarm     <= 1'b0;
      err       <= 1'b0;
      prog      <= 1'b0;
    end else begin
      err <= 1'b0;
      case (st)
        S_ENTRY, S_PROG: begin
          if (key_dig) begin
            if (digit_cnt < 3'd4) begin
              entry_buf <= {entry_buf[11:0], Code};
              digit_cnt <= digit_cnt + 3'd1;
            end
          end else if (key_clr) begin
            entry_buf <= '0;
            digit_cnt <= '0;
            if (st == S_PROG) begin
              st       <= S_OPEN;
              prog     <= 1'b0;
              unlock   <= 1'b1;
              fail_cnt <= '0;
            end
          end else if (key_ent) begin
            if (st == S_ENTRY) begin
              if (digit_cnt == 3'd4) begin
                st <= S_CHECK;
              end else begin
                st        <= S_FAIL;
                err       <= 1'b1;
                fail_cnt  <= sat_inc(fail_cnt);
                entry_buf <= '0;
                digit_cnt <= '0;
              end
            end else begin
              entry_buf <= '0;
              digit_cnt <= '0;
              if (digit_cnt == 3'd4) begin
                pw   <= entry_buf;
                st   <= S_ENTRY;
                prog <= 1'b0;
              end else begin
                err <= 1'b1;
              end
            end
          end
        end
        S_CHECK: begin
          entry_buf <= '0;
          digit_cnt <= '0;
          if (match) begin
            st       <= S_OPEN;
            unlock   <= 1'b1;
            fail_cnt <= '0;
          end else begin
            st       <= S_FAIL;
            err      <= 1'b1;
            fail_cnt <= sat_inc(fail_cnt);
          end
        end
        S_OPEN: begin
          // Expiry wins over a simultaneous enter key so the window never overruns.
          if (tmr_zero) begin
            st     <= S_ENTRY;
            unlock <= 1'b0;
          end else if (key_ent) begin
            st     <= S_PROG;
            unlock <= 1'b0;
            prog   <= 1'b1;
          end
        end
        S_FAIL: begin
          if (fail_cnt >= MAX_FAIL) begin
            st    <= S_LOCKOUT;
            alarm <= 1'b1;
          end else begin
            st <= S_ENTRY;
          end
        end
        S_LOCKOUT: begin
          if (tmr_zero) begin
            st       <= S_ENTRY;
            alarm    <= 1'b0;
            fail_cnt <= '0;
          end
        end
        default: begin
          st <= S_ENTRY;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lock_ctrl.sv
// Bench for lock_ctrl: directed scenarios plus random key traffic against a reference model.
module tb_lock_ctrl;

  localparam int UNL = 1000;
  localparam int LCK = 5000;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] Code  = 4'd0;
  logic       Valid = 1'b0;
  logic       unlock;
  logic       alarm;
  logic       err;
  logic       prog;
  logic [2:0] digit_cnt;

  int total = 0;
  int bad   = 0;
  int unl_cnt = 0;
  int alm_cnt = 0;
  int err_cnt = 0;

  lock_ctrl #(
    .DEFAULT_PW     (16'h1234),
    .UNLOCK_CYCLES  (32'd1000),
    .LOCKOUT_CYCLES (32'd5000),
    .MAX_FAIL       (2'd3)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .Code      (Code),
    .Valid     (Valid),
    .unlock    (unlock),
    .alarm     (alarm),
    .err       (err),
    .prog      (prog),
    .digit_cnt (digit_cnt)
  );

  always #5 clock = ~clock;

  // Reference model: entered digits as a queue, password as four digits,
  // remaining unlock/alarm time as plain cycle counts.
  int digits[$];
  int pw_d[4];
  int open_left;
  int lock_left;
  int fails;
  bit checking;
  bit failing;
  bit in_prog;
  bit err_m;

  task automatic check_val(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    digits.delete();
    pw_d = '{1, 2, 3, 4};
    open_left = 0;
    lock_left = 0;
    fails     = 0;
    checking  = 0;
    failing   = 0;
    in_prog   = 0;
    err_m     = 0;
  endtask

  task automatic bump_fail();
    failing = 1;
    err_m   = 1;
    if (fails < 3) fails++;
    digits.delete();
  endtask

  task automatic model_step(input bit v, input int c);
    bit ok;
    err_m = 0;
    if (lock_left > 0) begin
      lock_left--;
      if (lock_left == 0) fails = 0;
    end else if (failing) begin
      failing = 0;
      if (fails >= 3) lock_left = LCK;
    end else if (checking) begin
      checking = 0;
      ok = (digits.size() == 4);
      for (int i = 0; i < digits.size() && i < 4; i++)
        if (digits[i] != pw_d[i]) ok = 0;
      if (ok) begin
        open_left = UNL;
        fails = 0;
        digits.delete();
      end else begin
        bump_fail();
      end
    end else if (open_left > 0) begin
      open_left--;
      if (open_left > 0 && v && c == 11) begin
        open_left = 0;
        in_prog = 1;
      end
    end else if (v && c <= 9) begin
      if (digits.size() < 4) digits.push_back(c);
    end else if (v && c == 10) begin
      digits.delete();
      if (in_prog) begin
        in_prog = 0;
        open_left = UNL;
        fails = 0;
      end
    end else if (v && c == 11) begin
      if (in_prog) begin
        if (digits.size() == 4) begin
          for (int i = 0; i < 4; i++) pw_d[i] = digits[i];
          in_prog = 0;
        end else begin
          err_m = 1;
        end
        digits.delete();
      end else if (digits.size() == 4) begin
        checking = 1;
      end else begin
        bump_fail();
      end
    end
  endtask

  function automatic int model_outs();
    int o;
    o = digits.size();
    if (in_prog)       o += 8;
    if (err_m)         o += 16;
    if (lock_left > 0) o += 32;
    if (open_left > 0) o += 64;
    return o;
  endfunction

  function automatic int dut_outs();
    return int'({unlock, alarm, err, prog, digit_cnt});
  endfunction

  // One clock: present the key, advance the model at the edge, compare just after it.
  task automatic tick(input bit v, input int c);
    Valid = v;
    Code  = c[3:0];
    @(posedge clock);
    model_step(v, c);
    #1;
    Valid = 1'b0;
    if (unlock) unl_cnt++;
    if (alarm)  alm_cnt++;
    if (err)    err_cnt++;
    check_val("outs", dut_outs(), model_outs());
  endtask

  task automatic key(input int c);
    tick(1'b1, c);
    tick(1'b0, 0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 0);
  endtask

  // '0'-'9' digits, '*' clear, '#' enter.
  task automatic enter(input string s);
    int c;
    for (int i = 0; i < s.len(); i++) begin
      if (s[i] == "*")      c = 10;
      else if (s[i] == "#") c = 11;
      else                  c = int'(s[i]) - 48;
      key(c);
    end
  endtask

  task automatic enter_pw();
    int p[4];
    p = pw_d;
    for (int i = 0; i < 4; i++) key(p[i]);
    key(11);
  endtask

  task automatic do_reset(input string tag);
    #2;
    reset = 1'b1;
    #1;
    check_val(tag, dut_outs(), 0);
    model_reset();
    @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    int r;
    model_reset();
    repeat (2) @(posedge clock);
    #1;
    check_val("rst_state", dut_outs(), 0);
    reset = 1'b0;

    // Correct code opens for exactly UNL cycles.
    unl_cnt = 0;
    enter("1234#");
    idle(UNL + 10);
    check_val("unlock_len", unl_cnt, UNL);

    // Three wrong codes: three err pulses, then alarm for LCK cycles, keys ignored.
    unl_cnt = 0; alm_cnt = 0; err_cnt = 0;
    enter("1235#");
    enter("1235#");
    enter("1235#");
    check_val("err_pulses", err_cnt, 3);
    enter("1234#");
    idle(LCK + 10);
    check_val("alarm_len", alm_cnt, LCK);
    check_val("no_unlock_lockout", unl_cnt, 0);

    // Short entry fails immediately and empties the buffer.
    err_cnt = 0;
    enter("12#");
    check_val("short_err", err_cnt, 1);
    check_val("short_cnt", int'(digit_cnt), 0);

    // Clear, then a fifth digit is ignored.
    enter("12*12345#");
    check_val("clr_unlock", int'(unlock), 1);
    idle(UNL);

    // Password change to 9876.
    enter("1234#");
    enter("#");
    check_val("prog_on", int'(prog), 1);
    enter("9876");
    check_val("prog_cnt4", int'(digit_cnt), 4);
    enter("#");
    check_val("prog_off", int'(prog), 0);
    enter("9876#");
    check_val("new_pw_unlock", int'(unlock), 1);
    idle(UNL);
    err_cnt = 0;
    enter("1234#");
    check_val("old_pw_rejected", err_cnt, 1);

    // Reset during PROG and during LOCKOUT.
    enter("9876#");
    enter("#");
    enter("55");
    do_reset("mid_prog_rst");
    enter("1234#");
    check_val("revert_unlock", int'(unlock), 1);
    idle(UNL);
    enter("1111#");
    enter("1111#");
    enter("1111#");
    idle(100);
    check_val("in_lockout", int'(alarm), 1);
    do_reset("mid_lock_rst");
    enter("1234#");
    check_val("post_lock_unlock", int'(unlock), 1);
    idle(UNL);

    // Random key traffic.
    for (int i = 0; i < 700; i++) begin
      r = $urandom_range(0, 11);
      if (r < 3) begin
        enter_pw();
      end else if (r == 3) begin
        for (int k = 0; k < 4; k++) key($urandom_range(0, 9));
        key(11);
      end else if (r == 4 || r == 5) begin
        tick(1'b1, $urandom_range(0, 15));
      end else if (r == 6) begin
        key(10);
      end else if (r == 7) begin
        key(11);
      end else if (r == 8) begin
        key($urandom_range(0, 9));
      end else begin
        idle($urandom_range(1, 20));
      end
      if (i == 350) do_reset("rand_rst");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/lock_ctrl.md
LOCK_CTRL -- requirements
Module: lock_ctrl

Interface
REQ-001 SHALL have parameter DEFAULT_PW, 16'h1234, power-on password as four BCD digits, first-entered digit in [15:12].
REQ-002 SHALL have parameter UNLOCK_CYCLES, 32'd1000, number of cycles unlock stays high.
REQ-003 SHALL have parameter LOCKOUT_CYCLES, 32'd5000, number of cycles of lockout after MAX_FAIL failures.
REQ-004 SHALL have parameter MAX_FAIL, 2'd3, consecutive failures that trigger lockout.
REQ-005 SHALL have port clock, input, 1, the single clock; all state changes on its rising edge.
REQ-006 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-007 SHALL have port Code, input, 4, key code from the keypad scanner: 0-9 digits, 10 = clear (*), 11 = enter (#).
REQ-008 SHALL have port Valid, input, 1, one-cycle key strobe from the scanner; Code is sampled only when Valid=1.
REQ-009 SHALL have port unlock, output, 1, high while the lock is open.
REQ-010 SHALL have port alarm, output, 1, high during lockout.
REQ-011 SHALL have port err, output, 1, one-cycle pulse on a rejected entry.
REQ-012 SHALL have port prog, output, 1, high while a new password is being entered.
REQ-013 SHALL have port digit_cnt, output, 3, number of digits buffered, 0-4.

Function
REQ-014 SHALL implement FSM states ENTRY, CHECK, OPEN, PROG, FAIL, LOCKOUT.
REQ-015 In ENTRY or PROG, a key with Valid=1 and Code 0-9 SHALL shift into a 16-bit buffer and increment digit_cnt when digit_cnt<4; the 5th and later digits are ignored.
REQ-016 In ENTRY or PROG, Code=10 SHALL clear the buffer and digit_cnt; in PROG it also returns to OPEN.
REQ-017 In ENTRY, Code=11 with digit_cnt=4 SHALL go to CHECK; with digit_cnt<4 it SHALL go to FAIL.
REQ-018 Codes 12-15 SHALL be ignored in every state.
REQ-019 CHECK SHALL last exactly one cycle; buffer==stored password goes to OPEN, otherwise to FAIL; the buffer and digit_cnt clear on leaving CHECK.
REQ-020 Entering OPEN SHALL clear the fail counter, load the timer with UNLOCK_CYCLES-1 and assert unlock from the next cycle.
REQ-021 OPEN SHALL return to ENTRY when the timer reaches 0, giving unlock high for exactly UNLOCK_CYCLES cycles.
REQ-022 Code=11 in OPEN SHALL go to PROG (unlock deasserts, prog asserts); Code=11 with digit_cnt=4 in PROG SHALL store the buffer as the new password and go to ENTRY.
REQ-023 Code=11 in PROG with digit_cnt<4 SHALL pulse err and remain in PROG with the buffer cleared.
REQ-024 FAIL SHALL last one cycle, assert err and increment the saturating fail counter.
REQ-025 From FAIL, the counter reaching MAX_FAIL SHALL go to LOCKOUT; otherwise FAIL SHALL go to ENTRY.
REQ-026 LOCKOUT SHALL assert alarm for exactly LOCKOUT_CYCLES cycles, ignore all Valid strobes, then clear the fail counter and go to ENTRY.
REQ-027 Valid arriving in CHECK or FAIL SHALL be dropped (no buffering).
REQ-028 All outputs SHALL be registered.

Reset
REQ-029 reset SHALL force state ENTRY, buffer 0, digit_cnt 0, fail counter 0, timer 0, password DEFAULT_PW, and unlock=alarm=err=prog=0, including mid-OPEN, mid-PROG and mid-LOCKOUT.

Structure
REQ-030 State encodings and the key constants KEY_CLR=10 and KEY_ENT=11 SHALL live in shared package lock_pkg.
REQ-031 The down-counter used for OPEN and LOCKOUT timing SHALL be one sub-module, lock_timer (load, value, zero flag).

Verification
REQ-032 Keys 1,2,3,4,# after reset -> CHECK, then unlock=1 for exactly 1000 cycles, then ENTRY.
REQ-033 Keys 1,2,3,5,# -> err pulse of 1 cycle, unlock=0; repeated three times -> alarm=1 for 5000 cycles, and keys during alarm have no effect.
REQ-034 Keys 1,2,# -> err after 1 cycle, digit_cnt returns to 0.
REQ-035 Keys 1,2,*,1,2,3,4,5,# -> buffer 1234 (the 5 is ignored) -> unlock.
REQ-036 Unlock, then keys #,9,8,7,6,# -> prog=1 during entry; a later 9,8,7,6,# unlocks and 1,2,3,4,# fails.
REQ-037 Assert reset mid-LOCKOUT and mid-PROG -> alarm=0, prog=0 immediately; the password reverts to 1234.
